// File: rtl/dds_profile_scheduler.sv
// rtl/dds_profile_scheduler.sv - timed profile queue and timestamp source for the DDS phase-accumulator MAC
module dds_profile_scheduler #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [47:0]                     s_start_time,
  input  logic [47:0]                     s_freq,
  input  logic [13:0]                     s_phase,
  input  logic                            s_phase_rst,
  input  logic                            ts_set,
  input  logic [47:0]                     ts_set_value,
  input  logic                            late_clear,
  output logic [47:0]                     time_offset,
  output logic [47:0]                     freq,
  output logic [13:0]                     phase,
  output logic [47:0]                     timestamp,
  output logic                            profile_applied,
  output logic                            late_error,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [47:0]   q_start [FIFO_DEPTH];
  logic [47:0]   q_freq  [FIFO_DEPTH];
  logic [13:0]   q_phase [FIFO_DEPTH];
  logic          q_rst   [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  logic [47:0]   ts_next;
  logic          push;
  logic          head_valid;
  logic [47:0]   head_start;
  logic          apply;
  logic          apply_late;

  // The dispatch compare uses the value the counter takes on this edge, so a
  // ts_set jump is honoured immediately and on-time profiles land exactly on
  // the cycle whose visible timestamp equals their start time.
  assign ts_next    = ts_set ? ts_set_value : timestamp + 48'd1;

  // Ready is derived from the registered count only: a pop in the same cycle
  // does not free a slot, which keeps ready off the dispatch compare path.
  assign s_ready    = !reset && (fifo_count < CW'(FIFO_DEPTH));
  assign push       = s_valid && s_ready;

  // Head eligibility uses the registered count, so an entry written on this
  // edge cannot be dispatched until the next one.
  assign head_valid = (fifo_count != '0);
  assign head_start = q_start[rd_ptr];
  assign apply      = head_valid && (head_start <= ts_next);
  assign apply_late = apply && (head_start < ts_next);

  // Profile storage; contents are don't-care outside the count window.
  always_ff @(posedge clk) begin
    if (push) begin
      q_start[wr_ptr] <= s_start_time;
      q_freq[wr_ptr]  <= s_freq;
      q_phase[wr_ptr] <= s_phase;
      q_rst[wr_ptr]   <= s_phase_rst;
    end
  end

  // Counter, queue pointers and the MAC parameter tuple, all updated on one edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      timestamp       <= '0;
      time_offset     <= '0;
      freq            <= '0;
      phase           <= '0;
      profile_applied <= 1'b0;
      late_error      <= 1'b0;
      fifo_count      <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
    end else begin
      timestamp       <= ts_next;
      profile_applied <= apply;
      fifo_count      <= fifo_count + CW'(push) - CW'(apply);
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (apply) begin
        rd_ptr <= rd_ptr + AW'(1);
        freq   <= q_freq[rd_ptr];
        phase  <= q_phase[rd_ptr];
        if (q_rst[rd_ptr]) begin
          time_offset <= head_start;
        end
      end
      if (apply_late) begin
        late_error <= 1'b1;
      end else if (late_clear) begin
        late_error <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dds_profile_scheduler.sv
// tb/tb_dds_profile_scheduler.sv - directed self-checking bench for dds_profile_scheduler
module tb_dds_profile_scheduler;

  logic        clk;
  logic        reset;
  logic        s_valid;
  logic        s_ready;
  logic [47:0] s_start_time;
  logic [47:0] s_freq;
  logic [13:0] s_phase;
  logic        s_phase_rst;
  logic        ts_set;
  logic [47:0] ts_set_value;
  logic        late_clear;
  logic [47:0] time_offset;
  logic [47:0] freq;
  logic [13:0] phase;
  logic [47:0] timestamp;
  logic        profile_applied;
  logic        late_error;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  dds_profile_scheduler #(.FIFO_DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .s_valid         (s_valid),
    .s_ready         (s_ready),
    .s_start_time    (s_start_time),
    .s_freq          (s_freq),
    .s_phase         (s_phase),
    .s_phase_rst     (s_phase_rst),
    .ts_set          (ts_set),
    .ts_set_value    (ts_set_value),
    .late_clear      (late_clear),
    .time_offset     (time_offset),
    .freq            (freq),
    .phase           (phase),
    .timestamp       (timestamp),
    .profile_applied (profile_applied),
    .late_error      (late_error),
    .fifo_count      (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] start;
    logic [47:0] f;
    logic [13:0] ph;
    logic        rst;
    logic        clr;
    logic [47:0] exp_ts;
    logic [47:0] exp_toff;
    logic        exp_late;
    logic [2:0]  exp_count;
  } vec_t;

  vec_t tbl [4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (timestamp %0d)", name, act, exp, timestamp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [47:0] st, input logic [47:0] f, input logic [13:0] ph, input logic rst);
    bit done;
    done = 0;
    s_start_time = st;
    s_freq       = f;
    s_phase      = ph;
    s_phase_rst  = rst;
    s_valid      = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      if (s_ready) done = 1;
      tick();
    end
    s_valid = 1'b0;
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL write_accept: got not-accepted expected accepted (start %0d)", st);
    end
  endtask

  task automatic run_until(input logic [47:0] ts);
    bit hit;
    hit = 0;
    for (int i = 0; i < 5000 && !hit; i++) begin
      if (timestamp == ts) hit = 1;
      else tick();
    end
    n_checks++;
    if (!hit) begin
      n_fail++;
      $display("FAIL run_until: got timestamp %0d expected %0d", timestamp, ts);
    end
  endtask

  initial begin
    tbl[0] = '{48'd200, 48'h0000_0000_0200, 14'h0200, 1'b1, 1'b0, 48'd200, 48'd200, 1'b0, 3'd3};
    tbl[1] = '{48'd200, 48'h0000_0000_0201, 14'h0201, 1'b0, 1'b1, 48'd201, 48'd200, 1'b1, 3'd2};
    tbl[2] = '{48'd300, 48'h0000_0000_0300, 14'h0300, 1'b1, 1'b0, 48'd300, 48'd300, 1'b1, 3'd1};
    tbl[3] = '{48'd400, 48'h0000_0000_0400, 14'h0400, 1'b0, 1'b1, 48'd400, 48'd300, 1'b0, 3'd0};

    reset = 1'b1; s_valid = 1'b0; s_start_time = '0; s_freq = '0; s_phase = '0;
    s_phase_rst = 1'b0; ts_set = 1'b0; ts_set_value = '0; late_clear = 1'b0;

    // reset state
    tick(); tick(); tick();
    chk("rst_timestamp", 64'(timestamp), 64'd0);
    chk("rst_freq", 64'(freq), 64'd0);
    chk("rst_phase", 64'(phase), 64'd0);
    chk("rst_toff", 64'(time_offset), 64'd0);
    chk("rst_applied", 64'(profile_applied), 64'd0);
    chk("rst_late", 64'(late_error), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ready", 64'(s_ready), 64'd0);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("free_run_ts", 64'(timestamp), 64'(i));
      chk("free_run_ready", 64'(s_ready), 64'd1);
    end

    // on-time profile
    run_until(48'd10);
    wr(48'd100, 48'h0001_0000_0000, 14'h1234, 1'b1);
    chk("ontime_count", 64'(fifo_count), 64'd1);
    run_until(48'd99);
    chk("ontime_pre_freq", 64'(freq), 64'd0);
    chk("ontime_pre_applied", 64'(profile_applied), 64'd0);
    chk("ontime_pre_toff", 64'(time_offset), 64'd0);
    tick();
    chk("ontime_ts", 64'(timestamp), 64'd100);
    chk("ontime_freq", 64'(freq), 64'h0001_0000_0000);
    chk("ontime_phase", 64'(phase), 64'h1234);
    chk("ontime_toff", 64'(time_offset), 64'd100);
    chk("ontime_applied", 64'(profile_applied), 64'd1);
    chk("ontime_late", 64'(late_error), 64'd0);
    tick();
    chk("ontime_pulse_end", 64'(profile_applied), 64'd0);
    chk("ontime_count_end", 64'(fifo_count), 64'd0);

    // late profile
    run_until(48'd50 + 48'd100);
    wr(48'd5, 48'h0000_0000_0050, 14'h0055, 1'b0);
    chk("late_no_bypass", 64'(profile_applied), 64'd0);
    tick();
    chk("late_applied", 64'(profile_applied), 64'd1);
    chk("late_flag", 64'(late_error), 64'd1);
    chk("late_freq", 64'(freq), 64'h50);
    chk("late_toff_kept", 64'(time_offset), 64'd100);
    late_clear = 1'b1;
    tick();
    late_clear = 1'b0;
    chk("late_cleared", 64'(late_error), 64'd0);

    // full queue, table-driven dispatch
    for (int i = 0; i < 4; i++) wr(tbl[i].start, tbl[i].f, tbl[i].ph, tbl[i].rst);
    chk("full_count", 64'(fifo_count), 64'd4);
    chk("full_ready", 64'(s_ready), 64'd0);
    run_until(48'd199);
    chk("full_pre_applied", 64'(profile_applied), 64'd0);
    chk("full_pre_ready", 64'(s_ready), 64'd0);
    for (int i = 0; i < 4; i++) begin
      run_until(tbl[i].exp_ts - 48'd1);
      late_clear = tbl[i].clr;
      tick();
      late_clear = 1'b0;
      chk("tbl_ts", 64'(timestamp), 64'(tbl[i].exp_ts));
      chk("tbl_applied", 64'(profile_applied), 64'd1);
      chk("tbl_freq", 64'(freq), 64'(tbl[i].f));
      chk("tbl_phase", 64'(phase), 64'(tbl[i].ph));
      chk("tbl_toff", 64'(time_offset), 64'(tbl[i].exp_toff));
      chk("tbl_late", 64'(late_error), 64'(tbl[i].exp_late));
      chk("tbl_count", 64'(fifo_count), 64'(tbl[i].exp_count));
      chk("tbl_ready", 64'(s_ready), 64'd1);
    end

    // ts_set jump onto a queued start time
    wr(48'd1000, 48'h0000_0000_1000, 14'h1000, 1'b0);
    tick();
    chk("jump_pre_applied", 64'(profile_applied), 64'd0);
    ts_set = 1'b1; ts_set_value = 48'd1000;
    tick();
    ts_set = 1'b0;
    chk("jump_ts", 64'(timestamp), 64'd1000);
    chk("jump_applied", 64'(profile_applied), 64'd1);
    chk("jump_freq", 64'(freq), 64'h1000);
    chk("jump_toff_kept", 64'(time_offset), 64'd300);
    chk("jump_late", 64'(late_error), 64'd0);
    tick();
    chk("jump_ts_next", 64'(timestamp), 64'd1001);

    // counter wrap
    ts_set = 1'b1; ts_set_value = 48'hFFFF_FFFF_FFFE;
    tick();
    ts_set = 1'b0;
    chk("wrap_ts0", 64'(timestamp), 64'hFFFF_FFFF_FFFE);
    tick();
    chk("wrap_ts1", 64'(timestamp), 64'hFFFF_FFFF_FFFF);
    tick();
    chk("wrap_ts2", 64'(timestamp), 64'd0);

    // reset with entries queued, write during reset dropped
    wr(48'd5000, 48'h1, 14'h1, 1'b1);
    wr(48'd5001, 48'h2, 14'h2, 1'b1);
    wr(48'd5002, 48'h3, 14'h3, 1'b1);
    chk("mid_count", 64'(fifo_count), 64'd3);
    reset = 1'b1;
    s_valid = 1'b1; s_start_time = 48'd30; s_freq = 48'h77; s_phase = 14'h77; s_phase_rst = 1'b1;
    #1;
    chk("mid_ready_in_reset", 64'(s_ready), 64'd0);
    tick();
    chk("mid_rst_count", 64'(fifo_count), 64'd0);
    chk("mid_rst_ts", 64'(timestamp), 64'd0);
    chk("mid_rst_freq", 64'(freq), 64'd0);
    chk("mid_rst_toff", 64'(time_offset), 64'd0);
    chk("mid_rst_late", 64'(late_error), 64'd0);
    s_valid = 1'b0;
    reset = 1'b0;
    tick();
    chk("post_rst_ts", 64'(timestamp), 64'd1);
    chk("post_rst_count", 64'(fifo_count), 64'd0);
    wr(48'd20, 48'h0000_0000_0020, 14'h0020, 1'b1);
    run_until(48'd20);
    chk("post_rst_applied", 64'(profile_applied), 64'd1);
    chk("post_rst_freq", 64'(freq), 64'h20);
    chk("post_rst_toff", 64'(time_offset), 64'd20);
    chk("post_rst_late", 64'(late_error), 64'd0);
    tick();
    chk("post_rst_quiet", 64'(profile_applied), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_profile_scheduler.md
# dds_profile_scheduler

Timed parameter source for the DDS phase-accumulator MAC. Accepts profile writes (start time, frequency, phase, phase-reset flag) over a valid/ready port, queues them in a small FIFO, and runs the 48-bit system timestamp counter. It drives the MAC's time-offset, frequency, phase and timestamp inputs as one registered, mutually consistent tuple, switching profiles exactly on the cycle whose timestamp equals the profile's start time.

## Interface
- FIFO_DEPTH, 4, profile queue depth (power of two, ≥2)
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- s_valid  in  1  profile write valid
- s_ready  out  1  profile write ready
- s_start_time  in  48  timestamp at which profile takes effect
- s_freq  in  48  frequency tuning word
- s_phase  in  14  phase offset word
- s_phase_rst  in  1  1: time_offset := start_time on apply; 0: time_offset kept
- ts_set  in  1  one-cycle pulse, load timestamp counter
- ts_set_value  in  48  value loaded by ts_set
- late_clear  in  1  clears late_error
- time_offset  out  48  to MAC timeoffset input
- freq  out  48  to MAC freq input
- phase  out  14  to MAC phase input
- timestamp  out  48  to MAC timestamp input (counter value)
- profile_applied  out  1  one-cycle pulse, new profile visible on outputs this cycle
- late_error  out  1  sticky, a profile was applied after its start time
- fifo_count  out  clog2(FIFO_DEPTH)+1  queued entries

## Operation
- Counter: ts_next = ts_set ? ts_set_value : timestamp+1; timestamp <= ts_next every cycle. Unsigned, wraps 2^48-1 -> 0 silently.
- Write: entry pushed when s_valid && s_ready. s_ready = !reset && (fifo_count < FIFO_DEPTH), computed on registered count (a same-cycle pop does not free a slot). Data must be stable while s_valid && !s_ready.
- Dispatch: head entry (if FIFO non-empty) is applied at a clock edge when head.start_time <= ts_next (unsigned). On apply, same edge: freq <= head.freq, phase <= head.phase, time_offset <= head.start_time if head.phase_rst else unchanged, pop head, profile_applied <= 1.
- Late: if head.start_time < ts_next at apply, late_error <= 1. late_error cleared by late_clear; set has priority over clear in the same cycle.
- At most one profile applied per cycle; queued entries with equal or past start times are applied on consecutive cycles, each flagged late except one exactly on time.
- Entry becomes eligible for dispatch the cycle after it is accepted (no write-to-dispatch bypass).
- ts_set takes effect for dispatch in the same cycle (comparison uses ts_next); backward jumps do not discard queued entries.
- Wrap: no wrap-aware compare; a start_time below the wrapped counter is treated as late.

## Timing
- Reset (reset=1 at edge): timestamp=0, time_offset=0, freq=0, phase=0, profile_applied=0, late_error=0, fifo_count=0, FIFO flushed, s_ready=0 while reset high. Reset mid-operation discards all queued entries; writes during reset are dropped.
- First cycle after reset: timestamp=1.
- Outputs all registered; time_offset/freq/phase/timestamp change on the same edge so the MAC never sees a mixed tuple.
- On-time profile: the first cycle with timestamp == start_time shows the new freq/phase/time_offset and profile_applied=1.
- Write-to-earliest-apply latency: accept at edge N, apply at edge N+1 at the earliest.
- Throughput: one write and one apply per cycle simultaneously.

## Test plan
- Reset release, no writes -> timestamp 0,1,2,… ; all other outputs 0; s_ready=1 from first cycle after reset.
- Write {start=100, freq=0x000100000000, phase=0x1234, rst=1} at timestamp 10 -> at timestamp 100: freq/phase updated, time_offset=100, profile_applied pulse, late_error=0; nothing changes at 99.
- Write start=5 when timestamp=50 -> applied the cycle after acceptance, late_error=1; late_clear pulse -> late_error=0.
- Fill 4 entries with start times 200,200,300,400 -> s_ready=0 with fifo_count=4; entries applied at 200, 201 (late), 300, 400; s_ready returns 1 after first pop.
- ts_set to 1000 while entry start=1000 queued -> applied in the cycle timestamp first reads 1000; phase_rst=0 keeps previous time_offset.
- Assert reset with 3 entries queued -> fifo_count=0, outputs zero next cycle; subsequent profile with start=20 applied normally.
